// File: rtl/key_expansion_ctrl_pkg.sv
// Shared types and constants for the AES-128 key expansion controller.
package key_expansion_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND_IDX = 4'(NUM_ROUNDS);

    // Entry i is the round constant used when producing round i+1.
    localparam logic [7:0] RCON [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_for(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        if (idx < LAST_ROUND_IDX) begin
            rc = RCON[idx];
        end
        return rc;
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word (purely combinational).
module key_expansion_ctrl_subword
    import key_expansion_ctrl_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key expansion controller: emits round keys 0..10 one per accepted
// handshake, computing each next key from the held key with a single SubWord.
module key_expansion_ctrl
    import key_expansion_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    state_t      state;
    state_t      state_next;
    logic        done_next;
    logic        accept;
    logic        last_round;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in, sub_out, t;
    logic [31:0] n0, n1, n2, n3;

    assign busy       = (state != IDLE);
    assign rk_valid   = (state == RUN);
    assign accept     = rk_valid && rk_ready;
    assign last_round = (round_idx == LAST_ROUND_IDX);

    assign {w0, w1, w2, w3} = round_key;
    assign sub_in = {w3[23:0], w3[31:24]};

    key_expansion_ctrl_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // round_idx is the round currently held, so it selects rcon for round_idx+1.
    assign t  = sub_out ^ {rcon_for(round_idx), 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && last_round) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Key/index only move on a start in IDLE or an accept below the last round.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_key <= '0;
            round_idx <= '0;
        end else if (state == IDLE && start) begin
            round_key <= key_in;
            round_idx <= '0;
        end else if (accept && !last_round) begin
            round_key <= {n0, n1, n2, n3};
            round_idx <= round_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl against an arithmetic AES key schedule model.
module tb_key_expansion_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_keys [11];
    logic [127:0] obs_keys [11];
    int           done_cycle;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_expansion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = xtime(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [127:0] k, input logic rdy);
        start    = s;
        key_in   = k;
        rk_ready = rdy;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle_reset(input string tag);
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_valid"}, 128'(rk_valid), 128'(0));
        checkOutput({tag, "_done"}, 128'(done), 128'(0));
        checkOutput({tag, "_idx"}, 128'(round_idx), 128'(0));
        checkOutput({tag, "_key"}, round_key, 128'(0));
    endtask

    // Drives one expansion and checks every cycle; abort_at < 0 disables the reset abort.
    task automatic run_expansion(input logic [127:0] key, input int stall_max, input bit pre_started,
                                 input int abort_at, input bit mid_start, input bit chain,
                                 input logic [127:0] chain_key, input string tag);
        int stall;
        int cycles;
        model_expand(key);
        if (!pre_started) applyStimulus(1'b1, key, 1'b0);
        cycles = 1;
        for (int k = 0; k < 11; k++) begin
            stall = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            for (int s = 0; s <= stall; s++) begin
                checkOutput($sformatf("%s_r%0d_valid", tag, k), 128'(rk_valid), 128'(1));
                checkOutput($sformatf("%s_r%0d_busy", tag, k), 128'(busy), 128'(1));
                checkOutput($sformatf("%s_r%0d_done", tag, k), 128'(done), 128'(0));
                checkOutput($sformatf("%s_r%0d_idx", tag, k), 128'(round_idx), 128'(k));
                checkOutput($sformatf("%s_r%0d_key", tag, k), round_key, exp_keys[k]);
                obs_keys[k] = round_key;
                if (k == abort_at) begin
                    rst = 1'b1;
                    applyStimulus(1'b1, ~key, 1'($urandom));
                    rst   = 1'b0;
                    start = 1'b0;
                    check_idle_reset({tag, "_abort"});
                    return;
                end
                if (mid_start && k == 4 && s == 0)
                    applyStimulus(1'b1, ~key, (s == stall));
                else
                    applyStimulus(1'b0, rand_key(), (s == stall));
                cycles++;
            end
        end
        done_cycle = cycles;
        checkOutput({tag, "_done_pulse"}, 128'(done), 128'(1));
        checkOutput({tag, "_done_valid"}, 128'(rk_valid), 128'(0));
        checkOutput({tag, "_done_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_done_idx"}, 128'(round_idx), 128'(10));
        checkOutput({tag, "_done_key"}, round_key, exp_keys[10]);
        if (chain) begin
            applyStimulus(1'b1, chain_key, 1'b0);
            start = 1'b0;
        end else begin
            applyStimulus(1'b0, rand_key(), 1'($urandom));
            checkOutput({tag, "_post_done"}, 128'(done), 128'(0));
            checkOutput({tag, "_post_valid"}, 128'(rk_valid), 128'(0));
            checkOutput({tag, "_hold_idx"}, 128'(round_idx), 128'(10));
            checkOutput({tag, "_hold_key"}, round_key, exp_keys[10]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_ref(8'(i));

        // Reset with start held high: reset must win.
        rst = 1'b1;
        applyStimulus(1'b1, rand_key(), 1'b1);
        applyStimulus(1'b1, rand_key(), 1'b1);
        check_idle_reset("reset");
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        check_idle_reset("idle");

        run_expansion(FIPS_KEY, 0, 1'b0, -1, 1'b0, 1'b0, '0, "fips");
        checkOutput("fips_round1", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("fips_round10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("fips_done_cycle", 128'(done_cycle), 128'(12));

        run_expansion('0, 0, 1'b0, -1, 1'b0, 1'b0, '0, "zero");
        checkOutput("zero_round1", obs_keys[1], 128'h62636363626363636263636362636363);
        checkOutput("zero_round10", obs_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_expansion(FIPS_KEY, 5, 1'b0, -1, 1'b0, 1'b0, '0, "stall_fips");
        for (int n = 0; n < 3; n++)
            run_expansion(rand_key(), 5, 1'b0, -1, 1'b0, 1'b0, '0, $sformatf("stall_rand%0d", n));

        run_expansion(rand_key(), 2, 1'b0, -1, 1'b1, 1'b0, '0, "mid_start");

        run_expansion(rand_key(), 1, 1'b0, 5, 1'b0, 1'b0, '0, "abort");
        run_expansion(rand_key(), 2, 1'b0, -1, 1'b0, 1'b0, '0, "after_abort");

        run_expansion(FIPS_KEY, 0, 1'b0, -1, 1'b0, 1'b1, '0, "b2b_first");
        run_expansion('0, 0, 1'b1, -1, 1'b0, 1'b0, '0, "b2b_second");
        checkOutput("b2b_round0", obs_keys[0], 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
